// File: rtl/txt_mem_arb.sv
// txt_mem_arb: arbiter for a single-port text-mode display RAM.
//   Three requesters share the RAM, one access per cycle, in priority order:
//   renderer read > clear-screen fill write > CPU write FIFO drain.
//
// Ports
//   clk, clr                    clock, synchronous active-low reset
//   vid_req, vid_addr           renderer read request / address
//   vid_data, vid_valid         read data, returned exactly two cycles after vid_req
//   cpu_wr, cpu_addr, cpu_data  CPU write into the write FIFO
//   cpu_full                    CPU write refused this cycle (FIFO full or clear busy)
//   cls_start, cls_char         start clear-screen with fill character
//   cls_busy                    drain/clear sequence in progress
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata        registered display-RAM port (1-cycle read latency)
//
// state | meaning
// IDLE  | normal arbitration, FIFO drains whenever renderer is idle
// DRAIN | clear requested, flushing CPU writes queued before it
// CLEAR | writing fill character to every cell, 0..CELLS-1
module txt_mem_arb #(
  parameter int CELLS = 1200,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        vid_req,
  input  logic [11:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  input  logic        cpu_wr,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        cpu_full,
  input  logic        cls_start,
  input  logic [7:0]  cls_char,
  output logic        cls_busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [11:0] CELLS_C = 12'(CELLS);
  localparam logic [11:0] LAST_C  = 12'(CELLS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  logic [1:0]    state;
  logic [11:0]   fifo_addr [DEPTH];
  logic [7:0]    fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic [11:0]   fill_cnt;
  logic [7:0]    fill_char;
  logic          rd_p1;
  logic          rd_p2;
  logic          push;
  logic          pop;

  assign cls_busy = (state != S_IDLE);
  // Fullness uses the registered count, so a same-cycle pop does not free a slot.
  assign cpu_full = (count == DEPTH_C) || cls_busy;
  // Out-of-range addresses are swallowed without occupying a FIFO slot.
  assign push = cpu_wr && !cpu_full && (cpu_addr < CELLS_C);
  assign pop  = !vid_req && (state != S_CLEAR) && (count != '0);
  assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fill_cnt  <= '0;
      fill_char <= '0;
      rd_p1     <= 1'b0;
      rd_p2     <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;

      // Read pipeline: request -> RAM address -> RAM data -> vid_data.
      rd_p1     <= vid_req;
      rd_p2     <= rd_p1;
      vid_valid <= rd_p2;
      if (rd_p2) vid_data <= mem_rdata;

      if (vid_req) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= vid_addr;
      end else if (state == S_CLEAR) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= fill_cnt;
        mem_wdata <= fill_char;
      end else if (pop) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (cls_start) begin
            fill_char <= cls_char;
            fill_cnt  <= '0;
            state     <= (count_nxt == '0) ? S_CLEAR : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count_nxt == '0) state <= S_CLEAR;
        end
        S_CLEAR: begin
          if (!vid_req) begin
            if (fill_cnt == LAST_C) begin
              fill_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              fill_cnt <= fill_cnt + 12'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/txt_mem_arb.md
TXT_MEM_ARB -- requirements
Module: txt_mem_arb

Interface
REQ-001 Parameter CELLS, default 1200, meaning number of character cells in display memory (40x30).
REQ-002 Parameter DEPTH, default 4, meaning CPU write-FIFO depth (power of two).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 clr  in  1  reset, synchronous, active-low.
REQ-005 vid_req  in  1  renderer read request, single-cycle pulse.
REQ-006 vid_addr  in  12  renderer read address.
REQ-007 vid_data  out  8  registered read data for the renderer.
REQ-008 vid_valid  out  1  one-cycle strobe; vid_data valid.
REQ-009 cpu_wr  in  1  CPU write strobe.
REQ-010 cpu_addr  in  12  CPU write address.
REQ-011 cpu_data  in  8  CPU write data (ASCII code).
REQ-012 cpu_full  out  1  CPU writes not accepted this cycle.
REQ-013 cls_start  in  1  clear-screen command pulse.
REQ-014 cls_char  in  8  fill character, sampled with cls_start.
REQ-015 cls_busy  out  1  clear-screen sequence in progress.
REQ-016 mem_en, mem_we  out  1 each  display-RAM enable / write enable, registered.
REQ-017 mem_addr  out  12; mem_wdata  out  8  registered RAM address / write data.
REQ-018 mem_rdata  in  8  RAM read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-019 Single-port display RAM SHALL be shared per cycle; priority: renderer read > clear write > FIFO write.
REQ-020 vid_req at edge N SHALL drive mem_en=1, mem_we=0, mem_addr=vid_addr after edge N; vid_data=mem_rdata and vid_valid=1 after edge N+2 (fixed 2-cycle latency, never stalled).
REQ-021 Back-to-back vid_req every cycle SHALL be served each cycle; all other sources stall meanwhile.
REQ-022 cpu_wr with cpu_full=0 and cpu_addr<CELLS SHALL push {addr,data} into FIFO; cpu_addr>=CELLS SHALL be discarded silently.
REQ-023 cpu_wr with cpu_full=1 SHALL be dropped; no FIFO state change.
REQ-024 cpu_full SHALL equal (FIFO count==DEPTH) OR cls_busy; fullness evaluated before any same-cycle pop.
REQ-025 FIFO SHALL pop the oldest entry in a cycle with no vid_req and FSM not CLEAR, driving mem_en=1, mem_we=1, addr/data of entry after that edge; strict FIFO order.
REQ-026 Simultaneous push and pop when not full SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 FSM states IDLE, DRAIN, CLEAR; reset state IDLE.
REQ-028 IDLE + cls_start: latch cls_char, clear counter=0; go CLEAR if FIFO empty (after same-cycle pop), else DRAIN.
REQ-029 DRAIN -> CLEAR when FIFO count reaches 0.
REQ-030 CLEAR: each cycle without vid_req SHALL write latched char to mem_addr=counter, counter+1; at write of address CELLS-1 -> IDLE.
REQ-031 cls_busy=1 in DRAIN and CLEAR; cls_start while busy SHALL be ignored.
REQ-032 mem_en=0 and mem_we=0 SHALL be driven in cycles with no granted access; mem_addr/mem_wdata hold previous value.
REQ-033 vid_valid SHALL be 0 except the single cycle per vid_req in REQ-020.

Reset
REQ-034 clr=0 at an edge SHALL set: FSM IDLE, FIFO empty, counter 0, vid_valid=0, vid_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cls_busy=0, cpu_full=0.
REQ-035 Reset mid-clear or mid-drain SHALL abort; pending FIFO entries and in-flight vid read lost, no vid_valid issued.
REQ-036 Inputs SHALL be ignored while clr=0.

Verification
REQ-037 vid_req, vid_addr=0x028, RAM[0x028]=0x41 -> vid_valid pulse 2 cycles later, vid_data=0x41.
REQ-038 5 cpu_wr in consecutive cycles during continuous vid_req -> first 4 accepted, 5th dropped (cpu_full=1); after vid_req stops, 4 writes appear in order, 1 per cycle.
REQ-039 cpu_wr cpu_addr=1200 -> no FIFO push, no RAM write.
REQ-040 2 entries queued, cls_start cls_char=0x20 -> DRAIN writes both, then 1200 writes of 0x20 to 0..1199, cls_busy falls after address 1199; vid_req interleaved every 8 cycles still gets 2-cycle latency.
REQ-041 cls_start while cls_busy=1 -> ignored; counter continues unchanged.
REQ-042 clr=0 at counter=500 in CLEAR -> next cycle all REQ-034 values, no further RAM writes.
